rr_decoder_arbiter: RTL and testbench

//   Round-robin arbiter that shares one 2-to-4 decode resource among 4 requesters.

---
 rtl/arb_pkg.sv | 19 +
 rtl/arb_dec2x4.sv | 16 +
 rtl/rr_decoder_arbiter.sv | 118 +++++++++++
 tb/tb_rr_decoder_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin decoder arbiter.
package arb_pkg;

  localparam int unsigned NREQ = 4;

  // FSM encodings
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // The pointer starts at the last requester, so requester 0 is searched first
  localparam logic [1:0] LAST_PTR_RST = 2'd3;

  // Result of a round-robin search
  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } search_t;

endpackage

// File: rtl/arb_dec2x4.sv
// 2-to-4 decoder with enable; q is all zero when e is low.
module arb_dec2x4 (
  input  logic [1:0] a,
  input  logic       e,
  output logic [3:0] q
);

  // Drive the selected output bit only while enabled
  always_comb begin
    q = 4'b0000;
    if (e) begin
      q[a] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for 4 requesters with a bounded hold time per tenure.
// The grant index and enable are registered and then decoded into a one-hot
// grant, so there is no combinational path from req to gnt.
module rr_decoder_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      gnt_idx,
  output logic            gnt_vld,
  output logic            busy
);

  // Last hold_cnt value of a tenure; reaching it forces a release
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [0:0]        state_q, state_d;
  logic [1:0]        gnt_idx_q, gnt_idx_d;
  logic [1:0]        last_ptr_q, last_ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  search_t           idle_win;
  search_t           rel_win;
  logic              release_now;

  // First set request scanning ptr+1 .. ptr+4 (mod 4); ptr itself is checked last
  function automatic search_t rr_search(input logic [NREQ-1:0] r, input logic [1:0] ptr);
    search_t    s;
    logic [1:0] i;
    s = '0;
    // Scan in reverse so the nearest candidate overwrites farther ones
    for (int k = NREQ; k >= 1; k--) begin
      i = ptr + 2'(k);
      if (r[i]) begin
        s.found = 1'b1;
        s.idx   = i;
      end
    end
    return s;
  endfunction

  // Candidate winners for leaving IDLE and for a release inside GRANT
  always_comb begin
    idle_win    = rr_search(req, last_ptr_q);
    rel_win     = rr_search(req, gnt_idx_q);
    release_now = !req[gnt_idx_q] || (hold_cnt_q == HOLD_LAST);
  end

  // Next-state logic for the FSM, grant index, pointer and hold counter
  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_ptr_d = last_ptr_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (idle_win.found) begin
          state_d    = ST_GRANT;
          gnt_idx_d  = idle_win.idx;
          hold_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          last_ptr_d = gnt_idx_q;
          if (rel_win.found) begin
            // Hand over directly; a lone requester at expiry lands on itself
            gnt_idx_d  = rel_win.idx;
            hold_cnt_d = '0;
          end else begin
            // gnt_idx keeps its old value while idle
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
          end
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_idx_q  <= 2'd0;
      last_ptr_q <= LAST_PTR_RST;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_ptr_q <= last_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Outputs decoded purely from registers
  always_comb begin
    gnt_vld = (state_q == ST_GRANT);
    busy    = gnt_vld;
    gnt_idx = gnt_idx_q;
  end

  arb_dec2x4 u_dec (
    .a (gnt_idx_q),
    .e (gnt_vld),
    .q (gnt)
  );

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Bench for rr_decoder_arbiter: two instances (MAX_HOLD=8 and MAX_HOLD=2) share
// clock, reset and req, and are checked against a tenure-level reference model.
module tb_rr_decoder_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;

  logic [3:0] gnt     [2];
  logic [1:0] gnt_idx [2];
  logic       gnt_vld [2];
  logic       busy    [2];
  logic [3:0] hc      [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner (-1 = none), cycles the owner has been shown, rotation pointer
  int         m_own  [2];
  int         m_held [2];
  int         m_last [2];
  int         m_idx  [2];
  int         maxh   [2] = '{8, 2};

  always #5 clk = ~clk;

  rr_decoder_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt[0]),
    .gnt_idx (gnt_idx[0]),
    .gnt_vld (gnt_vld[0]),
    .busy    (busy[0])
  );

  rr_decoder_arbiter #(.MAX_HOLD(2), .HOLD_W(4)) u_dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt[1]),
    .gnt_idx (gnt_idx[1]),
    .gnt_vld (gnt_vld[1]),
    .busy    (busy[1])
  );

  assign hc[0] = u_dut8.hold_cnt_q;
  assign hc[1] = u_dut2.hold_cnt_q;

  // Structural invariants, checked every cycle away from the active edge
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [3:0] dec;
      dec = gnt_vld[k] ? (4'b0001 << gnt_idx[k]) : 4'b0000;
      n_tests++;
      if (!$onehot0(gnt[k]) || (gnt_vld[k] !== (|gnt[k])) || (busy[k] !== gnt_vld[k])
          || (gnt[k] !== dec)) begin
        n_fail++;
        $display("FAIL invariant inst%0d: gnt=%b vld=%b busy=%b idx=%0d (need onehot0, vld==|gnt, busy==vld, gnt==decode)",
                 k, gnt[k], gnt_vld[k], busy[k], gnt_idx[k]);
      end
    end
  end

  function automatic int pick(input logic [3:0] r, input int from);
    for (int d = 1; d <= 4; d++) begin
      if (r[(from + d) % 4]) return (from + d) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k]  = -1;
      m_held[k] = 0;
      m_last[k] = 3;
      m_idx[k]  = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_own[k] = -1; m_held[k] = 0; m_last[k] = 3; m_idx[k] = 0;
      end else if (m_own[k] < 0) begin
        if (req != 4'b0000) begin
          m_own[k]  = pick(req, m_last[k]);
          m_idx[k]  = m_own[k];
          m_held[k] = 1;
        end
      end else if (!req[m_own[k]] || m_held[k] >= maxh[k]) begin
        m_last[k] = m_own[k];
        m_own[k]  = pick(req, m_last[k]);
        if (m_own[k] >= 0) begin
          m_idx[k]  = m_own[k];
          m_held[k] = 1;
        end else begin
          m_held[k] = 0;
        end
      end else begin
        m_held[k]++;
      end
    end
  endtask

  // One clock: advance the model on the edge, then compare #1 later
  task automatic step(input string name);
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 2; k++) begin
      logic [3:0] eg;
      eg = (m_own[k] >= 0) ? (4'b0001 << m_own[k]) : 4'b0000;
      n_tests++;
      if (gnt[k] !== eg || gnt_vld[k] !== (m_own[k] >= 0)) begin
        n_fail++;
        $display("FAIL %s model gnt inst%0d: got %b vld=%b, expected %b", name, k, gnt[k],
                 gnt_vld[k], eg);
      end
      n_tests++;
      if (gnt_idx[k] !== 2'(m_idx[k])) begin
        n_fail++;
        $display("FAIL %s model idx inst%0d: got %0d, expected %0d", name, k, gnt_idx[k],
                 m_idx[k]);
      end
      if (m_own[k] >= 0) begin
        n_tests++;
        if (hc[k] !== 4'(m_held[k] - 1)) begin
          n_fail++;
          $display("FAIL %s model hold_cnt inst%0d: got %0d, expected %0d", name, k, hc[k],
                   m_held[k] - 1);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step("reset");
    step("reset");
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    req   = 4'b1111;
    rst_n = 1'b0;
    step("reset_hold");
    step("reset_hold");
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (gnt[k] !== 4'b0000 || gnt_vld[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset inst%0d: gnt=%b vld=%b, expected 0000/0", k, gnt[k], gnt_vld[k]);
      end
    end
    rst_n = 1'b1;
    model_reset();
    step("reset_first");
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (gnt[k] !== 4'b0001) begin
        n_fail++;
        $display("FAIL reset_first inst%0d: gnt=%b, expected 0001", k, gnt[k]);
      end
    end
  endtask

  task automatic test_single();
    req = 4'b0000;
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step("single");
      n_tests++;
      if (gnt[0] !== 4'b0100) begin
        n_fail++;
        $display("FAIL single cycle %0d: gnt=%b, expected 0100", c, gnt[0]);
      end
    end
    req = 4'b0000;
    step("single_drop");
    n_tests++;
    if (gnt[0] !== 4'b0000 || gnt_vld[0] !== 1'b0 || gnt_idx[0] !== 2'd2) begin
      n_fail++;
      $display("FAIL single_drop: gnt=%b vld=%b idx=%0d, expected 0000/0/2", gnt[0],
               gnt_vld[0], gnt_idx[0]);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] seq [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                            4'b1000, 4'b1000, 4'b0001};
    req = 4'b0000;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      step("rotation");
      n_tests++;
      if (gnt[1] !== seq[c]) begin
        n_fail++;
        $display("FAIL rotation cycle %0d: gnt=%b, expected %b", c, gnt[1], seq[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    req = 4'b0000;
    do_reset();
    req = 4'b0010;
    step("b2b");
    req = 4'b1011;
    step("b2b");
    req = 4'b1001;
    step("b2b_handover");
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (gnt[k] !== 4'b1000 || gnt_idx[k] !== 2'd3) begin
        n_fail++;
        $display("FAIL b2b_handover inst%0d: gnt=%b idx=%0d, expected 1000/3", k, gnt[k],
                 gnt_idx[k]);
      end
    end
  endtask

  task automatic test_hold_expiry();
    req = 4'b0000;
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      step("expiry");
      n_tests++;
      if (gnt[0] !== 4'b0010 || hc[0] !== 4'(c % 8)) begin
        n_fail++;
        $display("FAIL expiry cycle %0d: gnt=%b hold_cnt=%0d, expected 0010/%0d", c, gnt[0],
                 hc[0], c % 8);
      end
    end
  endtask

  task automatic test_async_reset();
    req = 4'b0000;
    do_reset();
    req = 4'b1000;
    step("async_pre");
    step("async_pre");
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (gnt[k] !== 4'b0000 || gnt_vld[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL async_drop inst%0d: gnt=%b vld=%b, expected 0000/0", k, gnt[k],
                 gnt_vld[k]);
      end
    end
    rst_n = 1'b1;
    model_reset();
    step("async_restart");
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (gnt[k] !== 4'b1000) begin
        n_fail++;
        $display("FAIL async_restart inst%0d: gnt=%b, expected 1000", k, gnt[k]);
      end
    end
  endtask

  task automatic test_random();
    req = 4'b0000;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      step("random");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_back_to_back();
    test_hold_expiry();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
